// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and defaults for the EX-to-fetch redirect controller.
// The state enum is shared so the sub-module and any debug logic agree on encoding.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_e;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int SQUASH_W       = 3;

endpackage

// File: rtl/redirect_squash_timer.sv
// Load/decrement counter that times the post-redirect IF/ID squash window.
// done is high while the counter holds 1, i.e. during the last squash cycle.
module redirect_squash_timer
    import branch_redirect_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SQUASH_W-1:0] load_val,
    input  logic                dec,
    output logic                done
);

    logic [SQUASH_W-1:0] count_q;
    logic [SQUASH_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - SQUASH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == SQUASH_W'(1));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved taken jump/branch in EX into a handshaked PC redirect,
// flushes wrong-path stages, holds EX meanwhile and counts completed redirects.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_taken,
    input  logic              ex_stall,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              fetch_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              ex_hold,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam bit                HAS_SQUASH = (SQUASH_CYCLES > 0);
    localparam logic [SQUASH_W-1:0] SQ_LOAD  = SQUASH_W'(SQUASH_CYCLES);

    state_e              state_q;
    logic                redirect_valid_q;
    logic [ADDR_W-1:0]   redirect_pc_q;
    logic                flush_if_id_q;
    logic                flush_id_ex_q;
    logic                ex_hold_q;
    logic [CNT_W-1:0]    redirect_cnt_q;
    logic [CNT_W-1:0]    redirect_cnt_d;

    logic capture;
    logic accept;
    logic squash_done;

    assign capture = ex_valid & ex_taken & ~ex_stall;
    assign accept  = (state_q == REDIRECT) & fetch_ready;

    redirect_squash_timer u_squash_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (SQ_LOAD),
        .dec      (state_q == SQUASH),
        .done     (squash_done)
    );

    // Outputs are updated alongside the state so every port comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_if_id_q    <= 1'b0;
            flush_id_ex_q    <= 1'b0;
            ex_hold_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= ex_target;
                        flush_if_id_q    <= 1'b1;
                        flush_id_ex_q    <= 1'b1;
                        ex_hold_q        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (fetch_ready) begin
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                        flush_id_ex_q    <= 1'b0;
                        if (HAS_SQUASH) begin
                            state_q       <= SQUASH;
                            flush_if_id_q <= 1'b1;
                            ex_hold_q     <= 1'b1;
                        end else begin
                            state_q       <= IDLE;
                            flush_if_id_q <= 1'b0;
                            ex_hold_q     <= 1'b0;
                        end
                    end
                end
                SQUASH: begin
                    if (squash_done) begin
                        state_q       <= IDLE;
                        flush_if_id_q <= 1'b0;
                        ex_hold_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_q <= 1'b0;
                    redirect_pc_q    <= '0;
                    flush_if_id_q    <= 1'b0;
                    flush_id_ex_q    <= 1'b0;
                    ex_hold_q        <= 1'b0;
                end
            endcase
        end
    end

    // Saturating perf counter: sticks at all-ones instead of wrapping.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (accept && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_if_id_q;
    assign flush_id_ex    = flush_id_ex_q;
    assign ex_hold        = ex_hold_q;
    assign redirect_cnt   = redirect_cnt_q;

endmodule
